// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV opcodes, NOP encoding and fetch FSM states
package riscv_pkg;
    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] OPCODE_I      = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [31:0] INSTR_NOP    = 32'h00000013;
    typedef enum logic [1:0] {REQ, WAIT, DROP} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem request/response, redirect and decode handshake bundle
interface instr_fetch_unit_if #(parameter int XLEN = 64);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;
    logic [6:0]      id_opcode;
    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_opcode,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_opcode,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: small instruction buffer with flush; head is visible combinationally
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd, wr;
    assign dout  = mem[rd];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) mem[wr] <= din;
            wr    <= wr + AW'(push);
            rd    <= rd + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing single-outstanding imem fetches into a decode-facing FIFO
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2,
    localparam int             AW         = $clog2(FIFO_DEPTH)
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);
    fetch_state_t     state;
    logic             run, hs, push, pop, full, empty;
    logic [XLEN-1:0]  pc, req_pc;
    logic [AW:0]      count;
    logic [XLEN+31:0] head;
    // run holds requests off until the first edge after reset release
    assign bus.imem_req_valid = run && state == REQ && count < (AW+1)'(FIFO_DEPTH) && !bus.redirect_valid;
    assign bus.imem_req_addr  = pc;
    assign hs   = bus.imem_req_valid && bus.imem_req_ready;
    assign push = state == WAIT && bus.imem_resp_valid && !bus.redirect_valid;
    assign pop  = !empty && bus.id_ready && !bus.redirect_valid;
    assign bus.id_valid  = !empty;
    assign bus.id_pc     = head[XLEN+31:32];
    assign bus.id_instr  = head[31:0];
    assign bus.id_opcode = head[6:0];
    fetch_fifo #(.WIDTH(XLEN+32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(bus.redirect_valid),
        .din({req_pc, bus.imem_resp_data}), .dout(head), .count(count), .full(full), .empty(empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= REQ;
            run    <= 1'b0;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            run    <= 1'b1;
            pc     <= bus.redirect_valid ? bus.redirect_pc & ~XLEN'(3) : hs ? pc + XLEN'(4) : pc;
            req_pc <= hs ? pc : req_pc;
            // a redirect with no response pending in WAIT leaves one stale response to swallow
            state  <= state == REQ ? (hs ? WAIT : REQ)
                    : bus.imem_resp_valid ? REQ
                    : bus.redirect_valid ? DROP : state;
        end
    end
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule
